human_box_ctrl: RTL and testbench
=================================

# human_box_ctrl

Per-frame controller for the human-detector bounding-box datapath. It samples the detector's running min/max coordinates at each frame boundary and clears the detector for the next frame. It validates the box against size limits, smooths it across frames and holds it through short detection drop-outs. It publishes one stable box per frame to the overlay/stitching logic downstream.

## Interface
Parameters:
- W, 12, coordinate width (matches detector x/y outputs)
- MIN_W, 16, minimum accepted box width in pixels
- MIN_H, 32, minimum accepted box height in pixels
- HOLD_FRAMES, 8, consecutive missed frames before the track is dropped (1..255)
- SMOOTH_SHIFT, 2, smoothing strength; new box = old + ((new-old) >>> SMOOTH_SHIFT); 0 = no smoothing

Ports:
- clk  in  1  pixel clock, shared with the detector
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; 0 forces IDLE and drops the track
- per_frame_vsync  in  1  frame sync from the video pipeline; a rising edge marks end of frame
- det_x_min, det_x_max, det_y_min, det_y_max  in  W each  running box from the detector
- det_clear  out  1  one-cycle pulse that re-arms the detector min/max registers
- box_x_min, box_x_max, box_y_min, box_y_max  out  W each  published box, stable between updates
- box_valid  out  1  a track is currently held
- box_update  out  1  one-cycle pulse when the box_* and box_valid outputs change
- miss_cnt  out  8  current consecutive-miss count, saturating at HOLD_FRAMES

## Operation
- vsync edge detect: register vs_d; edge = per_frame_vsync & ~vs_d.
- FSM states:
  - IDLE: entered from reset or when enable=0. Leaves to WAIT when enable=1.
  - WAIT: on edge, go to CAPTURE. An edge seen in any state other than WAIT is ignored.
  - CAPTURE: latch det_* into cap_* and assert det_clear. Go to CHECK.
  - CHECK: hit = (cap_x_min <= cap_x_max) & (cap_y_min <= cap_y_max) & (x_max-x_min+1 >= MIN_W) & (y_max-y_min+1 >= MIN_H).
    - Width and height are computed in W+1 bits.
    - An empty detector (min=all-ones, max=0) is therefore a miss.
    - Go to FILTER.
  - FILTER:
    - hit & !box_valid: load cap_* directly; box_valid←1; miss_cnt←0.
    - hit & box_valid: each coordinate ← old + (d >>> SMOOTH_SHIFT).
      - d = cap - old, computed as signed W+1 bits with arithmetic (floor) shift.
      - Result is truncated to W bits; it cannot overflow because it lies between old and cap.
      - miss_cnt←0.
    - miss & box_valid: miss_cnt+1. If the new count equals HOLD_FRAMES, box_valid←0 and box_* ← 0. Otherwise box_* is held.
    - miss & !box_valid: nothing changes; miss_cnt stays at its current value.
    - Go to PUBLISH.
  - PUBLISH: box_update←1 for this cycle, issued every frame even if the values are unchanged. Go to WAIT.
- enable=0 in any state:
  - Next cycle: state IDLE, box_valid←0, box_* ←0, miss_cnt←0.
  - box_update pulses once on that cycle only if box_valid was 1.
  - det_clear is not issued.
- box_* and box_valid change only in FILTER, or on the disable/reset paths.

## Timing
- Reset (async, immediate): state IDLE; det_clear, box_update, box_valid = 0; box_* = 0; miss_cnt = 0; vs_d = 0.
- Let cycle E be the cycle in which edge=1 while in WAIT.
  - E+1: CAPTURE; det_clear high.
  - E+2: CHECK.
  - E+3: FILTER; box_* and box_valid registered at the end of this cycle.
  - E+4: PUBLISH; box_update high, new values visible.
- Latency is 4 cycles edge-to-update. The detector must hold det_* stable at least through E+1.
- A vsync held high for many cycles produces exactly one capture.
- Reset mid-sequence aborts it. No det_clear or box_update is emitted after reset assertion.

## Test plan
- Reset: assert rst mid-FILTER → all outputs 0 immediately. After release with enable=1 and no edge, state stays WAIT and no pulses occur.
- First acquisition: det box (x 100..200, y 50..150), rise vsync at E → det_clear at E+1 only. At E+4, box = (100,200,50,150), box_valid=1, box_update=1.
- Smoothing (SMOOTH_SHIFT=2): previous box as above; next frame det_x_min=200, det_x_max=196 → box_x_min=125 and box_x_max=199. The 196 case has d=-4, so floor(-4/4) = -1.
- Drop-out hysteresis (HOLD_FRAMES=8): after a valid track, feed empty frames (min=4095, max=0).
  - Frames 1-7: box held, box_valid=1, miss_cnt 1..7.
  - Frame 8: box_valid=0, box=0, miss_cnt=8.
  - A valid frame afterwards loads directly with no smoothing.
- Undersize rejection: det box of width 10 and height 100 with no track → box_valid stays 0 and box_update still pulses at E+4. With a track held, the same frame counts as a miss.
- Disable and edge filtering:
  - enable→0 while a track is held → next cycle box_valid=0 with one box_update pulse.
  - Re-enable, then give a second vsync edge in CHECK → ignored; exactly one det_clear and one box_update per frame.

Source files
------------

// File: rtl/human_box_ctrl.sv
// Per-frame bounding-box controller: samples the detector's running box at each
// vsync rising edge, validates it, smooths it across frames and holds it through drop-outs.
module human_box_ctrl #(
  parameter int W            = 12,
  parameter int MIN_W        = 16,
  parameter int MIN_H        = 32,
  parameter int HOLD_FRAMES  = 8,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         per_frame_vsync,
  input  logic [W-1:0] det_x_min,
  input  logic [W-1:0] det_x_max,
  input  logic [W-1:0] det_y_min,
  input  logic [W-1:0] det_y_max,
  output logic         det_clear,
  output logic [W-1:0] box_x_min,
  output logic [W-1:0] box_x_max,
  output logic [W-1:0] box_y_min,
  output logic [W-1:0] box_y_max,
  output logic         box_valid,
  output logic         box_update,
  output logic [7:0]   miss_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CAPTURE,
    CHECK,
    FILTER,
    PUBLISH
  } state_t;

  localparam logic [W:0] MIN_W_L = (W+1)'(MIN_W);
  localparam logic [W:0] MIN_H_L = (W+1)'(MIN_H);
  localparam logic [7:0] HOLD_L  = 8'(HOLD_FRAMES);

  state_t       state, state_next;
  logic         vs_d;
  logic         vs_edge;
  logic [W-1:0] cap_x_min, cap_x_max, cap_y_min, cap_y_max;
  logic [W:0]   cap_w, cap_h;
  logic         hit, hit_q;

  // Moves old toward cap by a floored fraction of the signed difference.
  function automatic logic [W-1:0] smooth(input logic [W-1:0] old_v,
                                          input logic [W-1:0] cap_v);
    logic signed [W:0] d;
    logic signed [W:0] step;
    d    = $signed({1'b0, cap_v}) - $signed({1'b0, old_v});
    step = d >>> SMOOTH_SHIFT;
    return W'($signed({1'b0, old_v}) + step);
  endfunction

  assign vs_edge = per_frame_vsync & ~vs_d;

  assign cap_w = {1'b0, cap_x_max} - {1'b0, cap_x_min} + (W+1)'(1);
  assign cap_h = {1'b0, cap_y_max} - {1'b0, cap_y_min} + (W+1)'(1);
  assign hit   = (cap_x_min <= cap_x_max) && (cap_y_min <= cap_y_max) &&
                 (cap_w >= MIN_W_L) && (cap_h >= MIN_H_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = WAIT;
        WAIT:    if (vs_edge) state_next = CAPTURE;
        CAPTURE: state_next = CHECK;
        CHECK:   state_next = FILTER;
        FILTER:  state_next = PUBLISH;
        PUBLISH: state_next = WAIT;
        default: state_next = IDLE;
      endcase
    end
  end

  // Pulses are registered so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d       <= 1'b0;
      det_clear  <= 1'b0;
      box_update <= 1'b0;
      box_valid  <= 1'b0;
      box_x_min  <= '0;
      box_x_max  <= '0;
      box_y_min  <= '0;
      box_y_max  <= '0;
      miss_cnt   <= '0;
      cap_x_min  <= '0;
      cap_x_max  <= '0;
      cap_y_min  <= '0;
      cap_y_max  <= '0;
      hit_q      <= 1'b0;
    end else begin
      vs_d       <= per_frame_vsync;
      det_clear  <= 1'b0;
      box_update <= 1'b0;
      if (!enable) begin
        box_update <= box_valid;
        box_valid  <= 1'b0;
        box_x_min  <= '0;
        box_x_max  <= '0;
        box_y_min  <= '0;
        box_y_max  <= '0;
        miss_cnt   <= '0;
      end else begin
        case (state)
          WAIT: begin
            if (vs_edge) det_clear <= 1'b1;
          end
          CAPTURE: begin
            cap_x_min <= det_x_min;
            cap_x_max <= det_x_max;
            cap_y_min <= det_y_min;
            cap_y_max <= det_y_max;
          end
          CHECK: begin
            hit_q <= hit;
          end
          FILTER: begin
            box_update <= 1'b1;
            if (hit_q) begin
              if (box_valid) begin
                box_x_min <= smooth(box_x_min, cap_x_min);
                box_x_max <= smooth(box_x_max, cap_x_max);
                box_y_min <= smooth(box_y_min, cap_y_min);
                box_y_max <= smooth(box_y_max, cap_y_max);
              end else begin
                box_x_min <= cap_x_min;
                box_x_max <= cap_x_max;
                box_y_min <= cap_y_min;
                box_y_max <= cap_y_max;
              end
              box_valid <= 1'b1;
              miss_cnt  <= '0;
            end else if (box_valid) begin
              miss_cnt <= miss_cnt + 8'd1;
              if (miss_cnt + 8'd1 == HOLD_L) begin
                box_valid <= 1'b0;
                box_x_min <= '0;
                box_x_max <= '0;
                box_y_min <= '0;
                box_y_max <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_human_box_ctrl.sv
// Directed self-checking bench for human_box_ctrl with hand-computed expected boxes.
module tb_human_box_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        per_frame_vsync;
  logic [11:0] det_x_min, det_x_max, det_y_min, det_y_max;
  logic        det_clear;
  logic [11:0] box_x_min, box_x_max, box_y_min, box_y_max;
  logic        box_valid;
  logic        box_update;
  logic [7:0]  miss_cnt;

  int checks = 0;
  int errors = 0;
  int dc_cnt, bu_cnt, dc_pos, bu_pos;

  human_box_ctrl #(
    .W(12), .MIN_W(16), .MIN_H(32), .HOLD_FRAMES(8), .SMOOTH_SHIFT(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .per_frame_vsync(per_frame_vsync),
    .det_x_min(det_x_min), .det_x_max(det_x_max),
    .det_y_min(det_y_min), .det_y_max(det_y_max),
    .det_clear(det_clear),
    .box_x_min(box_x_min), .box_x_max(box_x_max),
    .box_y_min(box_y_min), .box_y_max(box_y_max),
    .box_valid(box_valid), .box_update(box_update), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [11:0] xn, input logic [11:0] xx,
                               input logic [11:0] yn, input logic [11:0] yx);
    det_x_min = xn;
    det_x_max = xx;
    det_y_min = yn;
    det_y_max = yx;
  endtask

  task automatic checkBox(input string tag, input logic [11:0] xn, input logic [11:0] xx,
                          input logic [11:0] yn, input logic [11:0] yx,
                          input logic v, input logic [7:0] m);
    checkOutput({tag, "_x_min"}, 32'(box_x_min), 32'(xn));
    checkOutput({tag, "_x_max"}, 32'(box_x_max), 32'(xx));
    checkOutput({tag, "_y_min"}, 32'(box_y_min), 32'(yn));
    checkOutput({tag, "_y_max"}, 32'(box_y_max), 32'(yx));
    checkOutput({tag, "_valid"}, 32'(box_valid), 32'(v));
    checkOutput({tag, "_miss"},  32'(miss_cnt),  32'(m));
  endtask

  // Holds vsync high for the whole frame; glitch re-raises it while in CHECK.
  task automatic runFrame(input string tag, input logic [11:0] xn, input logic [11:0] xx,
                          input logic [11:0] yn, input logic [11:0] yx, input bit glitch);
    applyStimulus(xn, xx, yn, yx);
    per_frame_vsync = 1'b1;
    dc_cnt = 0; bu_cnt = 0; dc_pos = 0; bu_pos = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (det_clear)  begin dc_cnt++; dc_pos = k; end
      if (box_update) begin bu_cnt++; bu_pos = k; end
      if (glitch && k == 1) per_frame_vsync = 1'b0;
      if (glitch && k == 2) per_frame_vsync = 1'b1;
    end
    per_frame_vsync = 1'b0;
    tick();
    checkOutput({tag, "_dc_cnt"}, 32'(dc_cnt), 32'd1);
    checkOutput({tag, "_dc_pos"}, 32'(dc_pos), 32'd1);
    checkOutput({tag, "_bu_cnt"}, 32'(bu_cnt), 32'd1);
    checkOutput({tag, "_bu_pos"}, 32'(bu_pos), 32'd4);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    per_frame_vsync = 1'b0;
    applyStimulus(12'd0, 12'd0, 12'd0, 12'd0);
    #1;
    checkOutput("rst_det_clear", 32'(det_clear), 32'd0);
    checkOutput("rst_box_update", 32'(box_update), 32'd0);
    checkBox("rst", 12'd0, 12'd0, 12'd0, 12'd0, 1'b0, 8'd0);
    tick();
    tick();
    rst = 1'b0;
    enable = 1'b1;
    dc_cnt = 0; bu_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (det_clear)  dc_cnt++;
      if (box_update) bu_cnt++;
    end
    checkOutput("idle_dc", 32'(dc_cnt), 32'd0);
    checkOutput("idle_bu", 32'(bu_cnt), 32'd0);

    runFrame("acq", 12'd100, 12'd200, 12'd50, 12'd150, 1'b0);
    checkBox("acq", 12'd100, 12'd200, 12'd50, 12'd150, 1'b1, 8'd0);

    // 100->200: +25; 200->300: +25
    runFrame("sm1", 12'd200, 12'd300, 12'd50, 12'd150, 1'b0);
    checkBox("sm1", 12'd125, 12'd225, 12'd50, 12'd150, 1'b1, 8'd0);

    // 225->221: d=-4 -> -1; 50->47: d=-3 floors to -1
    runFrame("sm2", 12'd125, 12'd221, 12'd47, 12'd150, 1'b0);
    checkBox("sm2", 12'd125, 12'd224, 12'd49, 12'd150, 1'b1, 8'd0);

    for (int f = 1; f <= 7; f++) begin
      runFrame("hold", 12'd4095, 12'd0, 12'd4095, 12'd0, 1'b0);
      checkBox("hold", 12'd125, 12'd224, 12'd49, 12'd150, 1'b1, 8'(f));
    end
    runFrame("drop", 12'd4095, 12'd0, 12'd4095, 12'd0, 1'b0);
    checkBox("drop", 12'd0, 12'd0, 12'd0, 12'd0, 1'b0, 8'd8);
    runFrame("postdrop", 12'd4095, 12'd0, 12'd4095, 12'd0, 1'b0);
    checkBox("postdrop", 12'd0, 12'd0, 12'd0, 12'd0, 1'b0, 8'd8);

    runFrame("small_notrk", 12'd300, 12'd309, 12'd10, 12'd109, 1'b0);
    checkBox("small_notrk", 12'd0, 12'd0, 12'd0, 12'd0, 1'b0, 8'd8);

    runFrame("reacq", 12'd100, 12'd200, 12'd50, 12'd150, 1'b0);
    checkBox("reacq", 12'd100, 12'd200, 12'd50, 12'd150, 1'b1, 8'd0);

    runFrame("small_trk", 12'd300, 12'd309, 12'd10, 12'd109, 1'b0);
    checkBox("small_trk", 12'd100, 12'd200, 12'd50, 12'd150, 1'b1, 8'd1);

    enable = 1'b0;
    tick();
    checkOutput("dis_update", 32'(box_update), 32'd1);
    checkOutput("dis_det_clear", 32'(det_clear), 32'd0);
    checkBox("dis", 12'd0, 12'd0, 12'd0, 12'd0, 1'b0, 8'd0);
    tick();
    checkOutput("dis_update_once", 32'(box_update), 32'd0);
    enable = 1'b1;
    tick();
    tick();

    runFrame("glitch", 12'd100, 12'd200, 12'd50, 12'd150, 1'b1);
    checkBox("glitch", 12'd100, 12'd200, 12'd50, 12'd150, 1'b1, 8'd0);
    tick();
    tick();

    // Reset lands while the frame is in FILTER with a new box pending.
    applyStimulus(12'd400, 12'd500, 12'd60, 12'd160);
    per_frame_vsync = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst_det_clear", 32'(det_clear), 32'd0);
    checkOutput("midrst_box_update", 32'(box_update), 32'd0);
    checkBox("midrst", 12'd0, 12'd0, 12'd0, 12'd0, 1'b0, 8'd0);
    per_frame_vsync = 1'b0;
    tick();
    rst = 1'b0;
    dc_cnt = 0; bu_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (det_clear)  dc_cnt++;
      if (box_update) bu_cnt++;
    end
    checkOutput("postrst_dc", 32'(dc_cnt), 32'd0);
    checkOutput("postrst_bu", 32'(bu_cnt), 32'd0);
    checkOutput("postrst_valid", 32'(box_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
